// File: rtl/perf_trace_monitor_pkg.sv
// Shared types and constants for the perf/trace run monitor.
package perf_mon_pkg;

    localparam int unsigned TRACE_ADDR_W = 32;
    localparam int unsigned TRACE_DATA_W = 32;
    localparam logic [31:0] PC_NEVER     = 32'hffff_ffff;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_RUN     = 2'd1,
        MON_DONE    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_t;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/perf_trace_monitor_if.sv
// CPU store request and store-trace readout bus of the run monitor.
interface perf_trace_monitor_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TRACE_DEPTH = 16
);
    localparam int unsigned TCNT_W = $clog2(TRACE_DEPTH) + 1;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              trace_rd_en;
    logic              trace_rd_valid;
    logic [ADDR_W-1:0] trace_rd_addr;
    logic [DATA_W-1:0] trace_rd_data;
    logic [TCNT_W-1:0] trace_count;
    logic              trace_overflow;

    modport master (
        output mem_write, mem_addr, mem_wdata, trace_rd_en,
        input  trace_rd_valid, trace_rd_addr, trace_rd_data, trace_count, trace_overflow
    );

    modport slave (
        input  mem_write, mem_addr, mem_wdata, trace_rd_en,
        output trace_rd_valid, trace_rd_addr, trace_rd_data, trace_count, trace_overflow
    );
endinterface

// File: rtl/perf_trace_monitor_fifo.sv
// First-word-fall-through circular store-trace buffer with sticky overflow flag.
module perf_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter type entry_t = logic [63:0],
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop_req,
    input  entry_t           wr_entry,
    output entry_t           rd_entry,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               full, empty, pop_ok, push_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_req && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (push && !push_ok) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign rd_valid = !empty;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/perf_trace_monitor.sv
// Run monitor for the pipelined MIPS core: run gating, end/watchdog detection,
// saturating perf counters and an optional store trace (built when PERF_TRACE_EN is defined).
module perf_trace_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned NUM_EVT     = 4,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned ADDR_W      = TRACE_ADDR_W,
    parameter int unsigned DATA_W      = TRACE_DATA_W,
    parameter int unsigned TIMEOUT     = 25000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear,
    input  logic [31:0]              pc,
    input  logic [31:0]              pc_finished,
    input  logic                     retire,
    input  logic [NUM_EVT-1:0]       evt,
    perf_trace_monitor_if.slave      bus,
    output logic                     run_en,
    output logic                     done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instr_cnt,
    output logic [CNT_W-1:0]         store_cnt,
    output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);
    localparam int unsigned NUM_CNT = NUM_EVT + 3;
    localparam int unsigned TCNT_W  = $clog2(TRACE_DEPTH) + 1;

    mon_state_t           state_q, state_d;
    logic                 done_q, timeout_q;
    logic                 match, wd_hit;
    logic [NUM_CNT-1:0]   cnt_inc;
    logic [NUM_CNT*CNT_W-1:0] cnt_flat;

    assign match  = (state_q == MON_RUN) && (pc == pc_finished) && (pc_finished != PC_NEVER);
    assign run_en = (state_q == MON_RUN) && !match;
    assign wd_hit = (TIMEOUT != 0) && (64'(cycle_cnt) == 64'(TIMEOUT) - 64'd1);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = MON_IDLE;
        end else begin
            case (state_q)
                MON_IDLE: if (start) state_d = MON_RUN;
                MON_RUN: begin
                    if (match)       state_d = MON_DONE;
                    else if (wd_hit) state_d = MON_TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MON_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_d == MON_DONE);
            timeout_q <= (state_d == MON_TIMEOUT);
        end
    end

    assign done    = done_q;
    assign timeout = timeout_q;

    // Counter slots: 0 cycles, 1 retired instrs, 2 stores, 3.. event strobes.
    assign cnt_inc = {evt, bus.mem_write, retire, 1'b1};

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear)                                         cnt_d = '0;
            else if (run_en && cnt_inc[i] && (cnt_q != '1))    cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign cnt_flat[i*CNT_W +: CNT_W] = cnt_q;
    end

    assign cycle_cnt = cnt_flat[0*CNT_W +: CNT_W];
    assign instr_cnt = cnt_flat[1*CNT_W +: CNT_W];
    assign store_cnt = cnt_flat[2*CNT_W +: CNT_W];
    assign evt_cnt   = cnt_flat[3*CNT_W +: NUM_EVT*CNT_W];

`ifdef PERF_TRACE_EN
    trace_entry_t wr_entry, rd_entry;

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = TRACE_ADDR_W'(bus.mem_addr);
        wr_entry.data = TRACE_DATA_W'(bus.mem_wdata);
    end

    perf_trace_fifo #(
        .DEPTH   (TRACE_DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (bus.mem_write && run_en),
        .pop_req  (bus.trace_rd_en),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .rd_valid (bus.trace_rd_valid),
        .count    (bus.trace_count),
        .overflow (bus.trace_overflow)
    );

    assign bus.trace_rd_addr = ADDR_W'(rd_entry.addr);
    assign bus.trace_rd_data = DATA_W'(rd_entry.data);
`else
    logic unused_trace_rd_en;

    assign unused_trace_rd_en = bus.trace_rd_en;
    assign bus.trace_rd_valid = 1'b0;
    assign bus.trace_rd_addr  = ADDR_W'(0);
    assign bus.trace_rd_data  = DATA_W'(0);
    assign bus.trace_count    = TCNT_W'(0);
    assign bus.trace_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_perf_trace_monitor.sv
// Directed self-checking bench for perf_trace_monitor (both trace build options).
module tb_perf_trace_monitor;
    import perf_mon_pkg::*;

`ifdef PERF_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        start = 1'b0, clear = 1'b0, retire = 1'b0;
    logic [31:0] pc = '0, pcf = 32'h40;
    logic [3:0]  evt = '0;

    logic        run_en_a, done_a, timeout_a, run_en_b, done_b, timeout_b;
    logic [31:0] cycle_a, instr_a, store_a;
    logic [127:0] evt_a;
    logic [3:0]  cycle_b, instr_b, store_b;
    logic [15:0] evt_b;

    int n_vec = 0;
    int n_bad = 0;

    perf_trace_monitor_if #(.ADDR_W(32), .DATA_W(32), .TRACE_DEPTH(16)) bus_a ();
    perf_trace_monitor_if #(.ADDR_W(32), .DATA_W(32), .TRACE_DEPTH(16)) bus_b ();

    always #5 clk = ~clk;

    perf_trace_monitor #(.CNT_W(32), .NUM_EVT(4), .TRACE_DEPTH(16), .ADDR_W(32), .DATA_W(32), .TIMEOUT(100)) dut_a (
        .clk(clk), .reset(rst_a), .start(start), .clear(clear), .pc(pc), .pc_finished(pcf),
        .retire(retire), .evt(evt), .bus(bus_a.slave), .run_en(run_en_a), .done(done_a),
        .timeout(timeout_a), .cycle_cnt(cycle_a), .instr_cnt(instr_a), .store_cnt(store_a), .evt_cnt(evt_a)
    );

    perf_trace_monitor #(.CNT_W(4), .NUM_EVT(4), .TRACE_DEPTH(16), .ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(rst_b), .start(start), .clear(clear), .pc(pc), .pc_finished(pcf),
        .retire(retire), .evt(evt), .bus(bus_b.slave), .run_en(run_en_b), .done(done_b),
        .timeout(timeout_b), .cycle_cnt(cycle_b), .instr_cnt(instr_b), .store_cnt(store_b), .evt_cnt(evt_b)
    );

    typedef struct {
        logic        start, wr, rd;
        logic [31:0] pc, addr, data;
        logic        e_run;
        logic [31:0] e_cycle, e_store;
        logic        e_valid;
        logic [4:0]  e_count;
        logic [31:0] e_haddr, e_hdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] tr(input logic [63:0] v);
        return TR ? v : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic head_chk(input string nm, input logic [31:0] ea, input logic [31:0] ed);
        chk({nm, "_addr"}, bus_a.trace_rd_valid ? bus_a.trace_rd_addr : 32'd0, tr(ea));
        chk({nm, "_data"}, bus_a.trace_rd_valid ? bus_a.trace_rd_data : 32'd0, tr(ed));
    endtask

    initial begin
        //          start wr rd  pc     addr   data  run cyc st  v  cnt haddr  hdata
        vecs[0] = '{1'b1, 0, 0, 32'h0,  32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0,  32'h0};
        vecs[1] = '{1'b0, 1, 0, 32'h0,  32'h54, 32'h7, 1, 0, 0, 0, 0, 32'h0,  32'h0};
        vecs[2] = '{1'b0, 1, 0, 32'h0,  32'h58, 32'h9, 1, 1, 1, 1, 1, 32'h54, 32'h7};
        vecs[3] = '{1'b0, 1, 0, 32'h40, 32'h5c, 32'h3, 0, 2, 2, 1, 2, 32'h54, 32'h7};
        vecs[4] = '{1'b0, 0, 1, 32'h0,  32'h0,  32'h0, 0, 2, 2, 1, 2, 32'h54, 32'h7};
        vecs[5] = '{1'b0, 0, 1, 32'h0,  32'h0,  32'h0, 0, 2, 2, 1, 1, 32'h58, 32'h9};
        vecs[6] = '{1'b0, 0, 1, 32'h0,  32'h0,  32'h0, 0, 2, 2, 0, 0, 32'h0,  32'h0};
        vecs[7] = '{1'b0, 0, 0, 32'h0,  32'h0,  32'h0, 0, 2, 2, 0, 0, 32'h0,  32'h0};

        bus_a.mem_write = 1'b0; bus_a.mem_addr = '0; bus_a.mem_wdata = '0; bus_a.trace_rd_en = 1'b0;
        bus_b.mem_write = 1'b0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0; bus_b.trace_rd_en = 1'b0;

        #1 rst_a = 1'b1; rst_b = 1'b1;
        #2;
        chk("rst_run_en", run_en_a, 0);
        chk("rst_done", {done_a, timeout_a}, 0);
        chk("rst_cycle", cycle_a, 0);
        chk("rst_count", {bus_a.trace_rd_valid, bus_a.trace_overflow, bus_a.trace_count}, 0);
        #9 rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Program end on PC match: 10 counted cycles, match cycle excluded
        do_clear();
        pcf = 32'h40; pc = 32'h0; start = 1'b1;
        #2 chk("t1_idle_run_en", run_en_a, 0);
        tick();
        start = 1'b0; retire = 1'b1; evt = 4'b0110;
        for (int k = 0; k < 10; k++) tick();
        pc = 32'h40;
        #2;
        chk("t1_match_run_en", run_en_a, 0);
        chk("t1_match_done", done_a, 0);
        tick();
        retire = 1'b0; evt = 4'b0000; pc = 32'h0;
        #2;
        chk("t1_done", done_a, 1);
        chk("t1_cycle", cycle_a, 10);
        chk("t1_instr", instr_a, 10);
        chk("t1_evt0", evt_a[31:0], 0);
        chk("t1_evt1", evt_a[63:32], 10);
        chk("t1_evt2", evt_a[95:64], 10);
        chk("t1_timeout", timeout_a, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #2 chk("t1_start_ignored", {done_a, run_en_a}, 2'b10);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        #2;
        chk("t1_clear_prio", {done_a, run_en_a}, 2'b00);
        chk("t1_clear_cnt", cycle_a, 0);
        tick();

        // Two stores and in-order FWFT readout
        do_clear();
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; pc = vecs[i].pc;
            bus_a.mem_write = vecs[i].wr; bus_a.mem_addr = vecs[i].addr;
            bus_a.mem_wdata = vecs[i].data; bus_a.trace_rd_en = vecs[i].rd;
            #2;
            chk($sformatf("t2_v%0d_run_en", i), run_en_a, vecs[i].e_run);
            chk($sformatf("t2_v%0d_cycle", i), cycle_a, vecs[i].e_cycle);
            chk($sformatf("t2_v%0d_store", i), store_a, vecs[i].e_store);
            chk($sformatf("t2_v%0d_valid", i), bus_a.trace_rd_valid, tr(vecs[i].e_valid));
            chk($sformatf("t2_v%0d_count", i), bus_a.trace_count, tr(vecs[i].e_count));
            head_chk($sformatf("t2_v%0d_head", i), vecs[i].e_haddr, vecs[i].e_hdata);
            tick();
        end
        start = 1'b0; pc = 32'h0; bus_a.mem_write = 1'b0; bus_a.trace_rd_en = 1'b0;

        // Overflow: 17 stores into a 16-entry trace
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_a.mem_write = 1'b1; bus_a.mem_addr = 32'h100 + 32'(4 * i); bus_a.mem_wdata = 32'(i);
            tick();
        end
        bus_a.mem_write = 1'b0;
        #2;
        chk("t3_count", bus_a.trace_count, tr(16));
        chk("t3_overflow", bus_a.trace_overflow, tr(1));
        chk("t3_store", store_a, 17);
        head_chk("t3_head", 32'h100, 32'h0);

        // Full trace with simultaneous push and pop
        tick();
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_a.mem_write = 1'b1; bus_a.mem_addr = 32'h300 + 32'(4 * i); bus_a.mem_wdata = 32'h30 + 32'(i);
            tick();
        end
        bus_a.mem_addr = 32'h400; bus_a.mem_wdata = 32'haa; bus_a.trace_rd_en = 1'b1;
        #2;
        chk("t4_full_count", bus_a.trace_count, tr(16));
        head_chk("t4_head_pre", 32'h300, 32'h30);
        tick();
        bus_a.mem_write = 1'b0; bus_a.trace_rd_en = 1'b0;
        #2;
        chk("t4_count", bus_a.trace_count, tr(16));
        chk("t4_overflow", bus_a.trace_overflow, 0);
        chk("t4_store", store_a, 17);
        head_chk("t4_head_post", 32'h304, 32'h31);
        bus_a.trace_rd_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        bus_a.trace_rd_en = 1'b0;
        #2;
        chk("t4_tail_count", bus_a.trace_count, tr(1));
        head_chk("t4_tail", 32'h400, 32'haa);
        tick();

        // Watchdog: TIMEOUT=100 with an unreachable end PC
        do_clear();
        pcf = PC_NEVER; pc = 32'h1000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 99; k++) tick();
        #2;
        chk("t5_pre_timeout", timeout_a, 0);
        chk("t5_pre_cycle", cycle_a, 99);
        chk("t5_pre_run_en", run_en_a, 1);
        tick();
        #2;
        chk("t5_timeout", timeout_a, 1);
        chk("t5_done", done_a, 0);
        chk("t5_cycle", cycle_a, 100);
        chk("t5_run_en", run_en_a, 0);
        tick(); tick();
        #2 chk("t5_hold", {timeout_a, cycle_a}, {1'b1, 32'd100});

        // PC match on the watchdog cycle wins
        do_clear();
        pcf = 32'h40; pc = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 99; k++) tick();
        pc = 32'h40;
        tick();
        pc = 32'h0;
        #2;
        chk("t5b_done", {done_a, timeout_a}, 2'b10);
        chk("t5b_cycle", cycle_a, 99);

        // CNT_W=4 saturation, then asynchronous reset mid-run
        tick();
        do_clear();
        pcf = PC_NEVER; retire = 1'b1; evt = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        #2;
        chk("t6_cycle_sat", cycle_b, 15);
        chk("t6_instr_sat", instr_b, 15);
        chk("t6_evt0_sat", evt_b[3:0], 15);
        chk("t6_evt1", evt_b[7:4], 0);
        chk("t6_run_en", run_en_b, 1);
        chk("t6_b_misc", {done_b, timeout_b, store_b, bus_b.trace_rd_valid, bus_b.trace_overflow, bus_b.trace_count}, 0);
        rst_b = 1'b1;
        #1;
        chk("t6_rst_cycle", cycle_b, 0);
        chk("t6_rst_instr", instr_b, 0);
        chk("t6_rst_evt", evt_b, 0);
        chk("t6_rst_state", {run_en_b, done_b, timeout_b}, 0);
        retire = 1'b0; evt = 4'b0000;
        tick();
        rst_b = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
